// File: rtl/order_heap_pkg.sv
// Shared definitions for the order-book heap.
//   - command encodings carried on the engine/heap cmd bus
//   - FSM state encoding
//   - field accessors for the 32-bit order word
//     {price[31:16], side[15], bot[14], qty[13:0]}
package order_heap_pkg;

  typedef enum logic [1:0] {
    CMD_NOP    = 2'b00,
    CMD_PUSH   = 2'b01,
    CMD_POP    = 2'b10,
    CMD_UPDATE = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SIFT_UP   = 2'd1,
    ST_SIFT_DOWN = 2'd2
  } state_e;

  // Order word field accessors. Only PRICE is ever used as a key; the
  // rest are stored opaquely and exist for the engine side.
  function automatic logic [15:0] PRICE(input logic [31:0] w);
    return w[31:16];
  endfunction

  function automatic logic IS_BUY(input logic [31:0] w);
    return w[15];
  endfunction

  function automatic logic IS_BOT(input logic [31:0] w);
    return w[14];
  endfunction

  function automatic logic [13:0] QTY(input logic [31:0] w);
    return w[13:0];
  endfunction

endpackage

// File: rtl/order_heap_better.sv
// heap_better: combinational priority compare of two order words.
//   a, b   : order words
//   better : 1 when a's price is strictly better than b's
//            (greater for a max-heap, smaller for a min-heap).
// Equal prices are never "better", so equal keys never swap.
module heap_better
  import order_heap_pkg::*;
#(
  parameter int IS_MAX = 1
) (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        better
);

  if (IS_MAX != 0) begin : g_max
    assign better = PRICE(a) > PRICE(b);
  end else begin : g_min
    assign better = PRICE(a) < PRICE(b);
  end

endmodule

// File: rtl/order_heap.sv
// order_heap: one side of the order book as a binary heap priority queue.
// Best-priced order sits at index 0; one sift level is resolved per clock.
//   clk, rst_n : clock, async active-low reset
//   cmd        : NOP/PUSH/POP/UPDATE one-cycle pulse, ignored while busy
//   data_in    : order word for PUSH/UPDATE
//   root       : best order (0 when empty), valid while busy=0
//   empty/full/count : occupancy
//   busy       : operation in progress
//   done       : one-cycle completion pulse (also for rejected commands)
//   overflow   : sticky, PUSH while full
//   underflow  : sticky, POP/UPDATE while empty
module order_heap
  import order_heap_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int IS_MAX = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               cmd,
  input  logic [31:0]              data_in,
  output logic [31:0]              root,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   mem [DEPTH];
  state_e        state, state_nx;
  logic [AW-1:0] idx;
  logic [CW-1:0] cnt;

  // ---------------- occupancy / command decode ----------------
  logic          is_empty, is_full;
  logic          push_ok, pop_ok, upd_ok, err_ovf, err_unf, in_idle;
  logic [CW-1:0] last;

  assign is_empty = (cnt == '0);
  assign is_full  = (cnt == CW'(DEPTH));
  assign last     = cnt - CW'(1);
  assign in_idle  = (state == ST_IDLE);

  assign push_ok = in_idle && (cmd == CMD_PUSH)   && !is_full;
  assign pop_ok  = in_idle && (cmd == CMD_POP)    && !is_empty;
  assign upd_ok  = in_idle && (cmd == CMD_UPDATE) && !is_empty;
  assign err_ovf = in_idle && (cmd == CMD_PUSH)   &&  is_full;
  assign err_unf = in_idle && ((cmd == CMD_POP) || (cmd == CMD_UPDATE)) && is_empty;

  // ---------------- sift geometry ----------------
  // Child indices carry two extra bits so 2*idx+2 never wraps before the
  // bound check against count.
  logic [AW-1:0] par_a;
  logic [AW+1:0] lc, rc;
  logic          l_ok, r_ok;
  logic [AW-1:0] l_a, r_a, best_a;
  logic          up_bt, r_bt, dn_bt;
  logic          up_swap, dn_swap;

  assign par_a = (idx - AW'(1)) >> 1;
  assign lc    = {1'b0, idx, 1'b1};
  assign rc    = lc + (AW+2)'(1);
  assign l_ok  = lc < {1'b0, cnt};
  assign r_ok  = rc < {1'b0, cnt};
  // Truncated addresses stay in range even when the child is absent; the
  // compare result is then masked by l_ok/r_ok.
  assign l_a   = lc[AW-1:0];
  assign r_a   = rc[AW-1:0];

  heap_better #(.IS_MAX(IS_MAX)) u_cmp_up (
    .a(mem[idx]), .b(mem[par_a]), .better(up_bt)
  );

  // Right child wins only when strictly better; ties go left.
  heap_better #(.IS_MAX(IS_MAX)) u_cmp_lr (
    .a(mem[r_a]), .b(mem[l_a]), .better(r_bt)
  );

  assign best_a = (r_ok && r_bt) ? r_a : l_a;

  heap_better #(.IS_MAX(IS_MAX)) u_cmp_dn (
    .a(mem[best_a]), .b(mem[idx]), .better(dn_bt)
  );

  assign up_swap = (idx != '0) && up_bt;
  assign dn_swap = l_ok && dn_bt;

  // ---------------- FSM ----------------
  logic fin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    fin      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (push_ok)               state_nx = ST_SIFT_UP;
        else if (pop_ok || upd_ok) state_nx = ST_SIFT_DOWN;
      end
      ST_SIFT_UP: begin
        if (!up_swap) begin
          fin      = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      ST_SIFT_DOWN: begin
        if (!dn_swap) begin
          fin      = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // ---------------- control registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      // Rejected commands complete immediately so the initiator is never
      // left waiting on a done that will not come.
      done <= fin || err_ovf || err_unf;
      busy <= (state_nx != ST_IDLE);
      if (err_ovf) overflow  <= 1'b1;
      if (err_unf) underflow <= 1'b1;
      if (push_ok) begin
        idx <= cnt[AW-1:0];
        cnt <= cnt + CW'(1);
      end else if (pop_ok) begin
        idx <= '0;
        cnt <= last;
      end else if (upd_ok) begin
        idx <= '0;
      end else if ((state == ST_SIFT_UP) && up_swap) begin
        idx <= par_a;
      end else if ((state == ST_SIFT_DOWN) && dn_swap) begin
        idx <= best_a;
      end
    end
  end

  // ---------------- storage ----------------
  // Contents are don't-care after reset; count gates everything visible.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[cnt[AW-1:0]] <= data_in;
    end else if (pop_ok) begin
      mem[0] <= mem[last[AW-1:0]];
    end else if (upd_ok) begin
      mem[0] <= data_in;
    end else if ((state == ST_SIFT_UP) && up_swap) begin
      mem[idx]   <= mem[par_a];
      mem[par_a] <= mem[idx];
    end else if ((state == ST_SIFT_DOWN) && dn_swap) begin
      mem[idx]    <= mem[best_a];
      mem[best_a] <= mem[idx];
    end
  end

  // ---------------- outputs ----------------
  assign root  = is_empty ? 32'h0 : mem[0];
  assign empty = is_empty;
  assign full  = is_full;
  assign count = cnt;

endmodule

// File: tb/tb_order_heap.sv
// Scoreboard bench for order_heap. Two instances:
//   u0: IS_MAX=1, DEPTH=4  (bid book; ordering, overflow, underflow, busy)
//   u1: IS_MAX=0, DEPTH=64 (ask book; updates)
// Stimulus queues the expected post-operation view; a negedge monitor pops
// and compares on each done pulse.
module tb_order_heap;
  import order_heap_pkg::*;

  typedef struct {
    logic [31:0] root;
    int          cnt;
    logic        emp, ful, ovf, unf;
    int          lat;
    int          t0;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  cmd  [2];
  logic [31:0] din  [2];
  logic [31:0] root [2];
  logic        empty[2], full[2], busy[2], done[2], ovf[2], unf[2];
  logic [2:0]  cnt_a;
  logic [6:0]  cnt_b;

  int   cyc = 0;
  int   n_cmp = 0, n_bad = 0;
  int   rst_req = 0, rst_seen = 0;
  int   tmo_req = 0, tmo_seen = 0;
  exp_t q0[$], q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  order_heap #(.DEPTH(4), .IS_MAX(1)) u0 (
    .clk(clk), .rst_n(rst_n), .cmd(cmd[0]), .data_in(din[0]),
    .root(root[0]), .empty(empty[0]), .full(full[0]), .count(cnt_a),
    .busy(busy[0]), .done(done[0]), .overflow(ovf[0]), .underflow(unf[0])
  );

  order_heap #(.DEPTH(64), .IS_MAX(0)) u1 (
    .clk(clk), .rst_n(rst_n), .cmd(cmd[1]), .data_in(din[1]),
    .root(root[1]), .empty(empty[1]), .full(full[1]), .count(cnt_b),
    .busy(busy[1]), .done(done[1]), .overflow(ovf[1]), .underflow(unf[1])
  );

  function automatic logic [31:0] ow(input int p, input int q);
    logic [15:0] pp;
    logic [13:0] qq;
    pp = 16'(p);
    qq = 14'(q);
    return {pp, 2'b00, qq};
  endfunction

  function automatic int cnt_of(input int u);
    return (u == 0) ? int'(cnt_a) : int'(cnt_b);
  endfunction

  // ---------------- monitor ----------------
  task automatic chk(input int u, input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL u%0d %s: got %h want %h (t=%0t)", u, nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (tmo_req != tmo_seen) begin
      n_cmp += tmo_req - tmo_seen;
      n_bad += tmo_req - tmo_seen;
      tmo_seen = tmo_req;
    end
    if (rst_req != rst_seen) begin
      rst_seen = rst_req;
      for (int u = 0; u < 2; u++) begin
        chk(u, "rst_root",  root[u], 32'h0);
        chk(u, "rst_empty", 32'(empty[u]), 32'h1);
        chk(u, "rst_count", 32'(cnt_of(u)), 32'h0);
        chk(u, "rst_busy",  32'(busy[u]), 32'h0);
        chk(u, "rst_done",  32'(done[u]), 32'h0);
      end
    end
    for (int u = 0; u < 2; u++) begin
      if (done[u]) begin
        if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
          n_cmp++;
          n_bad++;
          $display("FAIL u%0d unexpected_done: got done=1 want no pulse (t=%0t)", u, $time);
        end else begin
          e = (u == 0) ? q0.pop_front() : q1.pop_front();
          chk(u, "root",      root[u], e.root);
          chk(u, "count",     32'(cnt_of(u)), 32'(e.cnt));
          chk(u, "empty",     32'(empty[u]), 32'(e.emp));
          chk(u, "full",      32'(full[u]), 32'(e.ful));
          chk(u, "overflow",  32'(ovf[u]), 32'(e.ovf));
          chk(u, "underflow", 32'(unf[u]), 32'(e.unf));
          chk(u, "latency",   32'(cyc - e.t0), 32'(e.lat));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // Called #1 after a posedge; returns #1 after the next posedge.
  task automatic send(input int u, input logic [1:0] c, input logic [31:0] d);
    cmd[u] = c;
    din[u] = d;
    @(posedge clk);
    #1;
    cmd[u] = CMD_NOP;
  endtask

  task automatic op(input int u, input logic [1:0] c, input logic [31:0] d,
                    input logic [31:0] r, input int n, input logic emp, input logic ful,
                    input logic ov, input logic un, input int lat);
    exp_t e;
    e.root = r; e.cnt = n; e.emp = emp; e.ful = ful;
    e.ovf = ov; e.unf = un; e.lat = lat; e.t0 = cyc;
    if (u == 0) q0.push_back(e); else q1.push_back(e);
    send(u, c, d);
  endtask

  task automatic settle(input int u);
    int left;
    left = (u == 0) ? q0.size() : q1.size();
    for (int i = 0; i < 20 && left != 0; i++) begin
      @(posedge clk);
      left = (u == 0) ? q0.size() : q1.size();
    end
    if (left != 0) begin
      $display("FAIL u%0d done_timeout: got %0d pending want 0", u, left);
      tmo_req++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      cmd[u] = CMD_NOP;
      din[u] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset during SIFT_UP: operation aborted, no done afterwards.
    send(0, CMD_PUSH, ow(55, 1));
    rst_n = 1'b0;
    rst_req++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Bid book ordering.
    op(0, CMD_PUSH, ow(100, 10), ow(100, 10), 1, 0, 0, 0, 0, 2); settle(0);
    op(0, CMD_PUSH, ow(300, 10), ow(300, 10), 2, 0, 0, 0, 0, 3); settle(0);
    op(0, CMD_PUSH, ow(200, 10), ow(300, 10), 3, 0, 0, 0, 0, 2); settle(0);
    op(0, CMD_POP,  '0,          ow(200, 10), 2, 0, 0, 0, 0, 2); settle(0);
    op(0, CMD_POP,  '0,          ow(100, 10), 1, 0, 0, 0, 0, 2); settle(0);
    op(0, CMD_POP,  '0,          32'h0,       0, 1, 0, 0, 0, 2); settle(0);

    // Fill DEPTH=4, then overflow; heap ends as [40,30,20,10].
    op(0, CMD_PUSH, ow(10, 1), ow(10, 1), 1, 0, 0, 0, 0, 2); settle(0);
    op(0, CMD_PUSH, ow(20, 2), ow(20, 2), 2, 0, 0, 0, 0, 3); settle(0);
    op(0, CMD_PUSH, ow(30, 3), ow(30, 3), 3, 0, 0, 0, 0, 3); settle(0);
    op(0, CMD_PUSH, ow(40, 4), ow(40, 4), 4, 0, 1, 0, 0, 4); settle(0);
    op(0, CMD_PUSH, ow(50, 5), ow(40, 4), 4, 0, 1, 1, 0, 1); settle(0);

    // Drain, then underflow.
    op(0, CMD_POP, '0, ow(30, 3), 3, 0, 0, 1, 0, 3); settle(0);
    op(0, CMD_POP, '0, ow(20, 2), 2, 0, 0, 1, 0, 2); settle(0);
    op(0, CMD_POP, '0, ow(10, 1), 1, 0, 0, 1, 0, 2); settle(0);
    op(0, CMD_POP, '0, 32'h0,     0, 1, 0, 1, 0, 2); settle(0);
    op(0, CMD_POP, '0, 32'h0,     0, 1, 0, 1, 1, 1); settle(0);

    // POP while busy is ignored: single done, count 1.
    op(0, CMD_PUSH, ow(7, 1), ow(7, 1), 1, 0, 0, 1, 1, 2);
    send(0, CMD_POP, '0);
    settle(0);
    repeat (4) @(posedge clk);
    #1;

    // Ask book: min-heap with updates.
    op(1, CMD_PUSH,   ow(500, 1), ow(500, 1), 1, 0, 0, 0, 0, 2); settle(1);
    op(1, CMD_PUSH,   ow(400, 2), ow(400, 2), 2, 0, 0, 0, 0, 3); settle(1);
    op(1, CMD_PUSH,   ow(450, 3), ow(400, 2), 3, 0, 0, 0, 0, 2); settle(1);
    op(1, CMD_UPDATE, ow(400, 5), ow(400, 5), 3, 0, 0, 0, 0, 2); settle(1);
    op(1, CMD_UPDATE, ow(600, 6), ow(450, 3), 3, 0, 0, 0, 0, 3); settle(1);
    op(1, CMD_POP,    '0,         ow(500, 1), 2, 0, 0, 0, 0, 3); settle(1);

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
